// File: rtl/bmem_burst_responder.sv
// bmem_burst_responder: bmem memory end with a read queue and 4-beat bursts; `define BMEM_LFSR_JITTER_EN adds 0..7 cycles of read latency
module bmem_burst_responder #(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 8,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        proto_err
);
  localparam int PW = $clog2(QDEPTH);
  typedef enum logic [1:0] {W_IDLE, W_B1, W_B2, W_B3} w_t;
  typedef enum logic [2:0] {R_IDLE, R_B0, R_B1, R_B2, R_B3} r_t;
  w_t ws_q, ws_d;
  r_t rs_q, rs_d;
  logic [255:0] mem [2**ADDR_W];
  logic [26:0] qa_q [QDEPTH];
  logic [26:0] qa_d [QDEPTH];
  logic [8:0] qc_q [QDEPTH];
  logic [8:0] qc_d [QDEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic en_q, err_q, err_d;
  logic [ADDR_W-1:0] widx_q, widx_d, hidx;
  logic [191:0] wb_q, wb_d;
  logic [26:0] ra_q, ra_d;
  logic [255:0] line_q, line_d;
  logic [8:0] cd0;
  logic [1:0] beat;
  logic push, wacc, start, pop, wr_en;
  logic unused_ok;
  assign unused_ok = ^bmem_addr[4:0];
`ifdef BMEM_LFSR_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign cd0 = 9'(LATENCY - 1) + 9'(lfsr_q[2:0]);
  // jitter source, free-running from the reset seed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= 16'hACE1;
    else lfsr_q <= lfsr_d;
`else
  assign cd0 = 9'(LATENCY - 1);
`endif
  // state registers; the line array itself is never reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q <= W_IDLE;
      rs_q <= R_IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      en_q <= 1'b0;
      err_q <= 1'b0;
      widx_q <= '0;
      wb_q <= '0;
      ra_q <= '0;
      line_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qa_q[i] <= '0;
        qc_q[i] <= '0;
      end
    end else begin
      ws_q <= ws_d;
      rs_q <= rs_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      en_q <= 1'b1;
      err_q <= err_d;
      widx_q <= widx_d;
      wb_q <= wb_d;
      ra_q <= ra_d;
      line_q <= line_d;
      qa_q <= qa_d;
      qc_q <= qc_d;
    end
  end
  // a completed write burst lands in the array on its last beat
  always_ff @(posedge clk)
    if (wr_en) mem[widx_q] <= {bmem_wdata, wb_q};
  // next state: request acceptance, read queue, write and response FSMs
  always_comb begin
    bmem_ready = en_q && cnt_q != (PW+1)'(QDEPTH) && ws_q == W_IDLE;
    push = bmem_ready && bmem_read && !bmem_write;
    wacc = bmem_ready && bmem_write && !bmem_read;
    start = cnt_q != '0 && qc_q[rp_q] == '0;
    pop = start && (rs_q == R_IDLE || rs_q == R_B3);
    wr_en = ws_q == W_B3 && bmem_write;
    hidx = qa_q[rp_q][ADDR_W-1:0];
    err_d = err_q || (bmem_ready && bmem_read && bmem_write) || (!bmem_ready && bmem_read)
          || (!bmem_ready && bmem_write && ws_q == W_IDLE) || (ws_q != W_IDLE && !bmem_write);
    for (int i = 0; i < QDEPTH; i++) begin
      qa_d[i] = qa_q[i];
      qc_d[i] = qc_q[i] == '0 ? '0 : qc_q[i] - 9'd1;
    end
    if (push) begin
      qa_d[wp_q] = bmem_addr[31:5];
      qc_d[wp_q] = cd0;
    end
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    ws_d = ws_q == W_IDLE ? (wacc ? W_B1 : W_IDLE) : (bmem_write && ws_q != W_B3) ? w_t'(ws_q + 2'd1) : W_IDLE;
    widx_d = wacc ? bmem_addr[ADDR_W+4:5] : widx_q;
    wb_d = wb_q;
    if (wacc) wb_d[63:0] = bmem_wdata;
    if (ws_q == W_B1) wb_d[127:64] = bmem_wdata;
    if (ws_q == W_B2) wb_d[191:128] = bmem_wdata;
    rs_d = (rs_q == R_IDLE || rs_q == R_B3) ? (start ? R_B0 : R_IDLE) : r_t'(rs_q + 3'd1);
    ra_d = pop ? qa_q[rp_q] : ra_q;
    line_d = pop ? ((wr_en && widx_q == hidx) ? {bmem_wdata, wb_q} : mem[hidx]) : line_q;
  end
  // response outputs are zero outside a burst
  always_comb begin
    bmem_rvalid = rs_q != R_IDLE;
    beat = 2'(rs_q - 3'd1);
    bmem_raddr = bmem_rvalid ? {ra_q, 5'b0} : '0;
    bmem_rdata = bmem_rvalid ? line_q[{beat, 6'd0} +: 64] : '0;
    proto_err = err_q;
  end
endmodule

// File: tb/tb_bmem_burst_responder.sv
// tb_bmem_burst_responder: randomized bench against a cycle-level behavioural model of the responder
`timescale 1ns/1ps
module tb_bmem_burst_responder;
  localparam int AW = 6, L = 8, QD = 4;
  logic clk = 0, rst_n = 0;
  logic [31:0] bmem_addr = '0;
  logic bmem_read = 0, bmem_write = 0;
  logic [63:0] bmem_wdata = '0;
  logic bmem_ready, bmem_rvalid, proto_err;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  int vectors = 0, miscompares = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  bmem_burst_responder #(.ADDR_W(AW), .LATENCY(L), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
    .proto_err(proto_err));

  typedef struct packed { logic [31:0] a; logic [31:0] due; } rq_t;
  logic [255:0] mem [2**AW];
  rq_t pend[$];
  int e = 0, wcnt = 0, bstart = 0;
  logic m_en = 0, m_err = 0, b_act = 0;
  logic [AW-1:0] widx = '0;
  logic [255:0] wline = '0, bline = '0;
  logic [31:0] baddr = '0;
  logic [15:0] lfsr = 16'hACE1;

  function automatic bit m_rdy();
    return m_en && pend.size() < QD && wcnt == 0;
  endfunction

  // reference: reads become due LATENCY(+jitter) edges after accept and are served one 4-beat burst at a time, in order
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      m_en = 0; m_err = 0; wcnt = 0; b_act = 0; lfsr = 16'hACE1;
    end else begin
      bit rdy;
      int j;
      rdy = m_rdy();
      e++;
      j = 0;
`ifdef BMEM_LFSR_JITTER_EN
      j = int'(lfsr[2:0]);
`endif
      if (bmem_read && (!rdy || bmem_write)) m_err = 1;
      if (bmem_write && !rdy && wcnt == 0) m_err = 1;
      if (wcnt != 0) begin
        if (!bmem_write) begin
          m_err = 1; wcnt = 0;
        end else begin
          wline[wcnt*64 +: 64] = bmem_wdata;
          if (wcnt == 3) begin mem[widx] = wline; wcnt = 0; end
          else wcnt++;
        end
      end else if (rdy && bmem_write && !bmem_read) begin
        widx = bmem_addr[AW+4:5]; wline[63:0] = bmem_wdata; wcnt = 1;
      end
      if (b_act && e - bstart >= 4) b_act = 0;
      if (!b_act && pend.size() > 0 && int'(pend[0].due) <= e) begin
        b_act = 1; bstart = e; baddr = pend[0].a; bline = mem[baddr[AW+4:5]];
        void'(pend.pop_front());
      end
      if (rdy && bmem_read && !bmem_write) pend.push_back({{bmem_addr[31:5], 5'b0}, 32'(e + L + j)});
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      m_en = 1;
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", n, act, exp, e, $time);
    end
  endtask

  // every cycle: DUT outputs against the model
  always @(negedge clk) if (chk_en) begin
    logic xv;
    xv = b_act && (e - bstart) < 4;
    chk("ready", 64'(bmem_ready), 64'(m_rdy()));
    chk("rvalid", 64'(bmem_rvalid), 64'(xv));
    chk("raddr", 64'(bmem_raddr), xv ? 64'(baddr) : 64'd0);
    chk("rdata", bmem_rdata, xv ? bline[(e-bstart)*64 +: 64] : 64'd0);
    chk("proto_err", 64'(proto_err), 64'(m_err));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy();
    int k = 0;
    while (!m_rdy() && k < 300) begin tick(); k++; end
    if (k >= 300) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic rd(input logic [31:0] a);
    wait_rdy();
    bmem_addr = a; bmem_read = 1;
    tick();
    bmem_read = 0; bmem_addr = $urandom;
  endtask

  task automatic wr(input logic [31:0] a, input logic [255:0] ln);
    wait_rdy();
    bmem_addr = a; bmem_write = 1; bmem_wdata = ln[63:0];
    tick();
    for (int b = 1; b < 4; b++) begin
      bmem_addr = $urandom; bmem_wdata = ln[b*64 +: 64];
      tick();
    end
    bmem_write = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1 chk("rvalid_in_reset", 64'(bmem_rvalid), 64'd0);
    tick(); tick();
    rst_n = 1;
    tick();
    chk("ready_after_reset", 64'(bmem_ready), 64'd1);
  endtask

  function automatic logic [255:0] rline();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int cnt, first, last;
    logic [255:0] ln;
    tick(); tick();
    chk("ready_during_reset", 64'(bmem_ready), 64'd0);
    chk("rvalid_during_reset", 64'(bmem_rvalid), 64'd0);
    chk_en = 1;
    rst_n = 1;
    tick();
    chk("ready_first_cycle", 64'(bmem_ready), 64'd1);
    for (int i = 0; i < 2**AW; i++) wr({$urandom_range(0, 2**21-1), 6'(i), 5'(0)}, rline());
    // directed: write then read the same line, with literal timing and data
    ln = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    wr(32'h1ECEB000, ln);
    rd(32'h1ECEB000);
`ifndef BMEM_LFSR_JITTER_EN
    repeat (L-1) tick();
    chk("t1_before_latency", 64'(bmem_rvalid), 64'd0);
    tick();
    chk("t1_raddr", 64'(bmem_raddr), 64'h1ECEB000);
    chk("t1_beat0", bmem_rdata, 64'hAAAAAAAAAAAAAAAA);
    tick(); chk("t1_beat1", bmem_rdata, 64'hBBBBBBBBBBBBBBBB);
    tick(); chk("t1_beat2", bmem_rdata, 64'hCCCCCCCCCCCCCCCC);
    tick(); chk("t1_beat3", bmem_rdata, 64'hDDDDDDDDDDDDDDDD);
    chk("t1_beat3_valid", 64'(bmem_rvalid), 64'd1);
    tick(); chk("t1_after_burst", 64'(bmem_rvalid), 64'd0);
    rd(32'h1ECEB014);
    repeat (L) tick();
    chk("t2_raddr_masked", 64'(bmem_raddr), 64'h1ECEB000);
    chk("t2_beat0", bmem_rdata, 64'hAAAAAAAAAAAAAAAA);
`endif
    repeat (12) tick();
    // directed: four back-to-back reads fill the queue
    for (int i = 0; i < 4; i++) rd(32'h00001000 + 32'(i*32));
    chk("t3_ready_low_when_full", 64'(bmem_ready), 64'd0);
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 60; c++) begin
`ifndef BMEM_LFSR_JITTER_EN
      if (c == L-4) chk("t3_ready_before_pop", 64'(bmem_ready), 64'd0);
      if (c == L-3) chk("t3_ready_after_pop", 64'(bmem_ready), 64'd1);
`endif
      if (bmem_rvalid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      tick();
    end
    chk("t3_rvalid_cycles", 64'(cnt), 64'd16);
`ifndef BMEM_LFSR_JITTER_EN
    chk("t3_contiguous", 64'(last - first + 1), 64'd16);
`endif
    // random legal traffic, reads and writes overlapping
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0, 1: rd($urandom);
        2: wr($urandom, rline());
        default: repeat ($urandom_range(0, 3)) tick();
      endcase
    end
    repeat (60) tick();
    // protocol violations
    wait_rdy();
    bmem_addr = 32'h00000040; bmem_read = 1; bmem_write = 1;
    tick();
    bmem_read = 0; bmem_write = 0;
    tick();
    chk("t4_err_rw_same_cycle", 64'(proto_err), 64'd1);
    repeat (20) tick();
    rd(32'h00000040);
    repeat (20) tick();
    do_reset();
    chk("t4_err_cleared", 64'(proto_err), 64'd0);
    bmem_addr = 32'h00000060; bmem_write = 1; bmem_wdata = 64'h1111;
    tick();
    bmem_wdata = 64'h2222;
    tick();
    bmem_write = 0;
    tick();
    chk("t4_err_short_write", 64'(proto_err), 64'd1);
    rd(32'h00000060);
    repeat (20) tick();
    // reset in the middle of a read burst
    do_reset();
    rd(32'h00000080);
    repeat (L+2) tick();
    do_reset();
    for (int i = 0; i < 2**AW; i += 5) rd({21'h0, 6'(i), 5'(0)});
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: rd($urandom);
        1: wr($urandom, rline());
        default: tick();
      endcase
    end
    repeat (80) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
